// File: rtl/game_disp_pkg.sv
// Shared encodings for the guessing-game result display: game states and
// active-low seven-segment glyphs (bit7 = dp, bit0 = segment a).
package game_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_RESULT = 2'b10,
        ST_RSVD   = 2'b11
    } game_state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_Y     = 8'h91;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_BANG  = 8'h7D;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_O     = 8'hA3;
    localparam logic [7:0] SEG_S     = 8'h92;
    localparam logic [7:0] SEG_E     = 8'h86;

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment pattern for hex digits 0-F; dp stays off.
module seg_hex_decode (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
    end

endmodule

// File: rtl/result_display_ctrl.sv
// Drives the HEX digits and LEDs from the game state: latches the round verdict on
// entry to RESULT, keeps saturating win/loss tallies, and runs its own LED chase and blink.
module result_display_ctrl
    import game_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int NUM_LEDS    = 7,
    parameter int GUESS_W     = 5,
    parameter int BLINK_TICKS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [1:0]              state,
    input  logic [GUESS_W-1:0]      guess,
    input  logic [GUESS_W-1:0]      target,
    output logic [8*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_LEDS-1:0]     led_out,
    output logic                    is_win,
    output logic [7:0]              win_cnt,
    output logic [7:0]              loss_cnt
);

    localparam int BC_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [1:0]           prev_state;
    logic [GUESS_W-1:0]   tgt_q,   tgt_d;
    logic [NUM_LEDS-1:0]  chase,   chase_d;
    logic [BC_W-1:0]      blink_cnt, blink_cnt_d;
    logic                 blink_phase, blink_phase_d;
    logic                 is_win_d;
    logic [7:0]           win_cnt_d, loss_cnt_d;
    logic                 entry;
    logic [7:0]           tgt_byte;
    logic [7:0]           seg_tgt_hi, seg_tgt_lo, seg_cnt_hi, seg_cnt_lo;
    logic [8*NUM_DIGITS-1:0] hex_d;
    logic [NUM_LEDS-1:0]  led_d;

    // Round bookkeeping. The display is built from these next-state values so the
    // registered outputs show the new round exactly one cycle after the entry edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        entry         = (state == ST_RESULT) && (prev_state != ST_RESULT);
        is_win_d      = is_win;
        win_cnt_d     = win_cnt;
        loss_cnt_d    = loss_cnt;
        tgt_d         = tgt_q;
        chase_d       = chase;
        blink_cnt_d   = blink_cnt;
        blink_phase_d = blink_phase;

        if (entry) begin
            is_win_d = (guess == target);
            if (guess == target) begin
                if (win_cnt != 8'hFF) win_cnt_d = win_cnt + 8'd1;
            end else begin
                if (loss_cnt != 8'hFF) loss_cnt_d = loss_cnt + 8'd1;
            end
            tgt_d         = target;
            chase_d       = NUM_LEDS'(1);
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (state == ST_RESULT) begin
            if (tick) begin
                chase_d = {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
                if (BLINK_TICKS > 0) begin
                    if (32'(blink_cnt) == 32'(BLINK_TICKS - 1)) begin
                        blink_cnt_d   = '0;
                        blink_phase_d = ~blink_phase;
                    end else begin
                        blink_cnt_d = blink_cnt + BC_W'(1);
                    end
                end
            end
        end else begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end
    end

    assign tgt_byte = 8'(tgt_d);

    seg_hex_decode u_tgt_hi (.nibble(tgt_byte[7:4]),  .seg(seg_tgt_hi));
    seg_hex_decode u_tgt_lo (.nibble(tgt_byte[3:0]),  .seg(seg_tgt_lo));
    seg_hex_decode u_cnt_hi (.nibble(win_cnt_d[7:4]), .seg(seg_cnt_hi));
    seg_hex_decode u_cnt_lo (.nibble(win_cnt_d[3:0]), .seg(seg_cnt_lo));

    always_comb begin
        hex_d = {NUM_DIGITS{SEG_BLANK}};
        led_d = '0;
        case (state)
            ST_PLAY: begin
                hex_d[15:0] = {seg_cnt_hi, seg_cnt_lo};
            end
            ST_RESULT: begin
                hex_d[15:0] = {seg_tgt_hi, seg_tgt_lo};
                if (!blink_phase_d) begin
                    hex_d[47:16] = is_win_d ? {SEG_Y, SEG_A, SEG_Y, SEG_BANG}
                                            : {SEG_L, SEG_O, SEG_S, SEG_E};
                end
                led_d = is_win_d ? chase_d : '0;
            end
            default: begin
                led_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            prev_state  <= ST_IDLE;
            tgt_q       <= '0;
            chase       <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            is_win      <= 1'b0;
            win_cnt     <= 8'h00;
            loss_cnt    <= 8'h00;
            hex_out     <= {NUM_DIGITS{SEG_BLANK}};
            led_out     <= '0;
        end else begin
            prev_state  <= state;
            tgt_q       <= tgt_d;
            chase       <= chase_d;
            blink_cnt   <= blink_cnt_d;
            blink_phase <= blink_phase_d;
            is_win      <= is_win_d;
            win_cnt     <= win_cnt_d;
            loss_cnt    <= loss_cnt_d;
            hex_out     <= hex_d;
            led_out     <= led_d;
        end
    end

endmodule
